// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Purpose  : In-order retirement buffer. Hands out 3-bit dependency tags
//            (1..2^TAG_W-1, tag 0 = "no dependency") to issued instructions,
//            collects results by tag from the execution units, and retires
//            finished entries strictly in program order as one-cycle commit
//            pulses carrying {reg, data, tag} to the register file.
// Ports    : clk, rst (sync, active-low)     - clock / reset
//            pause, flush                    - freeze / discard everything
//            alloc_valid, alloc_rd           - issue-side allocation request
//            alloc_ready, alloc_tag          - free-slot flag, granted tag
//            wb_valid, wb_tag, wb_data       - result writeback
//            query_tag -> query_ready/_data  - reservation-station probe
//            commit, commit_reg/_data/_tag   - registered retirement pulse
//            count                           - occupied entries
// Config   : ROB_HEAD_BYPASS_EN - when defined, a writeback hitting a
//            not-yet-ready head entry retires it on the same edge, taking
//            commit_data straight from wb_data.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer #(
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [TAG_W-1:0]  query_tag,
  output logic              query_ready,
  output logic [DATA_W-1:0] query_data,
  output logic              commit,
  output logic [4:0]        commit_reg,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [TAG_W-1:0]  count
);

  // Tag 0 is reserved, so one code point of the tag space holds no slot.
  localparam int               DEPTH    = (1 << TAG_W) - 1;
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(DEPTH - 1);
  localparam logic [TAG_W-1:0] FULL_CNT = TAG_W'(DEPTH);
  localparam logic [TAG_W-1:0] ONE      = TAG_W'(1);

  // Flattened view of the per-slot storage.
  logic              slot_valid [DEPTH];
  logic              slot_ready [DEPTH];
  logic [4:0]        slot_rd    [DEPTH];
  logic [DATA_W-1:0] slot_data  [DEPTH];

  // Per-slot update strobes.
  logic [DEPTH-1:0]  wb_sel;
  logic [DEPTH-1:0]  alloc_sel;
  logic [DEPTH-1:0]  retire_sel;

  // Pointers, occupancy and commit port registers.
  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W-1:0]  count_q, count_d;
  logic              commit_q, commit_d;
  logic [4:0]        commit_reg_q, commit_reg_d;
  logic [DATA_W-1:0] commit_data_q, commit_data_d;
  logic [TAG_W-1:0]  commit_tag_q, commit_tag_d;

  logic              active;
  logic              do_alloc;
  logic              do_retire;
  logic              head_done;
  logic [TAG_W-1:0]  head_tag;
  logic [DATA_W-1:0] retire_data;
  logic [TAG_W-1:0]  query_idx;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  assign active      = !pause && !flush;
  assign alloc_ready = (count_q < FULL_CNT);
  assign alloc_tag   = tail_q + ONE;
  assign do_alloc    = alloc_valid && alloc_ready && active;
  assign head_tag    = head_q + ONE;

  // Head has its result already latched (state before the edge).
  assign head_done = (count_q != '0) && slot_valid[head_q] && slot_ready[head_q];

`ifdef ROB_HEAD_BYPASS_EN
  logic head_bypass;

  // A writeback that completes the waiting head retires it immediately.
  assign head_bypass = (count_q != '0) && slot_valid[head_q] && !slot_ready[head_q]
                       && wb_valid && (wb_tag == head_tag);
  assign do_retire   = active && (head_done || head_bypass);
  assign retire_data = head_done ? slot_data[head_q] : wb_data;
`else
  assign do_retire   = active && head_done;
  assign retire_data = slot_data[head_q];
`endif

  // --------------------------------------------------------------------------
  // Slot storage. Slot g carries tag g+1.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Writebacks to empty slots are dropped; a repeat writeback overwrites.
    assign wb_sel[g]     = wb_valid && valid_q && (wb_tag == TAG_W'(g + 1));
    assign alloc_sel[g]  = do_alloc  && (tail_q == TAG_W'(g));
    assign retire_sel[g] = do_retire && (head_q == TAG_W'(g));

    always_comb begin
      valid_d = valid_q;
      ready_d = ready_q;
      rd_d    = rd_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = 1'b0;
        ready_d = 1'b0;
      end else if (!pause) begin
        if (wb_sel[g]) begin
          ready_d = 1'b1;
          data_d  = wb_data;
        end
        // A slot is only allocated while empty, so this never races a
        // writeback to live data.
        if (alloc_sel[g]) begin
          valid_d = 1'b1;
          ready_d = 1'b0;
          rd_d    = alloc_rd;
        end
        // Retirement reads pre-edge contents; clearing last wins over a
        // same-edge writeback to the departing head.
        if (retire_sel[g]) begin
          valid_d = 1'b0;
          ready_d = 1'b0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        valid_q <= 1'b0;
        ready_q <= 1'b0;
        rd_q    <= '0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        ready_q <= ready_d;
        rd_q    <= rd_d;
        data_q  <= data_d;
      end
    end

    assign slot_valid[g] = valid_q;
    assign slot_ready[g] = ready_q;
    assign slot_rd[g]    = rd_q;
    assign slot_data[g]  = data_q;
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and commit port
  // --------------------------------------------------------------------------
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    commit_d      = 1'b0;          // pulse: only asserted on a real commit
    commit_reg_d  = commit_reg_q;
    commit_data_d = commit_data_q;
    commit_tag_d  = commit_tag_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (!pause) begin
      if (do_alloc) begin
        tail_d = (tail_q == LAST_IDX) ? '0 : tail_q + ONE;
      end
      if (do_retire) begin
        head_d = (head_q == LAST_IDX) ? '0 : head_q + ONE;
        // Entries targeting r0 leave without touching the register file.
        if (slot_rd[head_q] != 5'd0) begin
          commit_d      = 1'b1;
          commit_reg_d  = slot_rd[head_q];
          commit_data_d = retire_data;
          commit_tag_d  = head_tag;
        end
      end
      case ({do_alloc, do_retire})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commit_q      <= 1'b0;
      commit_reg_q  <= '0;
      commit_data_q <= '0;
      commit_tag_q  <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commit_q      <= commit_d;
      commit_reg_q  <= commit_reg_d;
      commit_data_q <= commit_data_d;
      commit_tag_q  <= commit_tag_d;
    end
  end

  // --------------------------------------------------------------------------
  // Query port. Tag 0 maps to no slot; the index is clamped so the array
  // read stays in range.
  // --------------------------------------------------------------------------
  assign query_idx   = (query_tag == '0) ? '0 : query_tag - ONE;
  assign query_ready = (query_tag != '0) && slot_valid[query_idx] && slot_ready[query_idx];
  assign query_data  = query_ready ? slot_data[query_idx] : '0;

  assign commit      = commit_q;
  assign commit_reg  = commit_reg_q;
  assign commit_data = commit_data_q;
  assign commit_tag  = commit_tag_q;
  assign count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer
// Purpose  : Self-checking bench for reorder_buffer. A queue-based model of
//            the buffer is compared against the DUT every cycle, and directed
//            scenarios add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reorder_buffer;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              pause;
  logic              flush;
  logic              alloc_valid;
  logic [4:0]        alloc_rd;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;
  logic [TAG_W-1:0]  query_tag;
  logic              query_ready;
  logic [DATA_W-1:0] query_data;
  logic              commit;
  logic [4:0]        commit_reg;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W-1:0]  commit_tag;
  logic [TAG_W-1:0]  count;

  always #5 clk = ~clk;

  reorder_buffer #(.TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pause       (pause),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
    .query_tag   (query_tag),
    .query_ready (query_ready),
    .query_data  (query_data),
    .commit      (commit),
    .commit_reg  (commit_reg),
    .commit_data (commit_data),
    .commit_tag  (commit_tag),
    .count       (count)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: the in-flight instructions in program order, oldest first.
  typedef struct {
    int          tag;
    int          rd;
    bit          rdy;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_next;
  logic        m_commit;
  logic [31:0] m_creg;
  logic [31:0] m_cdata;
  logic [31:0] m_ctag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every observable output against the model.
  task automatic compare_model();
    bit          exp_qr;
    logic [31:0] exp_qd;
    exp_qr = 1'b0;
    exp_qd = 32'h0;
    chk("count", 32'(count), 32'(mq.size()));
    chk("alloc_ready", 32'(alloc_ready), 32'(mq.size() < DEPTH));
    if (mq.size() < DEPTH) chk("alloc_tag", 32'(alloc_tag), 32'(m_next));
    chk("commit", 32'(commit), 32'(m_commit));
    chk("commit_reg", 32'(commit_reg), m_creg);
    chk("commit_data", commit_data, m_cdata);
    chk("commit_tag", 32'(commit_tag), m_ctag);
    foreach (mq[i]) begin
      if (mq[i].tag == int'(query_tag)) begin
        exp_qr = mq[i].rdy;
        exp_qd = mq[i].data;
      end
    end
    chk("query_ready", 32'(query_ready), 32'(exp_qr));
    if (exp_qr) chk("query_data", query_data, exp_qd);
    else if (query_tag == '0) chk("query_data_tag0", query_data, 32'h0);
  endtask

  // Advance the model by one clock edge from the current inputs.
  task automatic model_edge();
    bit          do_ret;
    bit          can_alloc;
    logic [31:0] rdata;
    ent_t        e;
    if (!rst) begin
      mq.delete();
      m_next   = 1;
      m_commit = 1'b0;
      m_creg   = 32'h0;
      m_cdata  = 32'h0;
      m_ctag   = 32'h0;
      return;
    end
    m_commit = 1'b0;
    if (flush) begin
      mq.delete();
      m_next = 1;
      return;
    end
    if (pause) return;
    can_alloc = (mq.size() < DEPTH);
    do_ret    = 1'b0;
    rdata     = 32'h0;
    if (mq.size() > 0 && mq[0].rdy) begin
      do_ret = 1'b1;
      rdata  = mq[0].data;
    end
`ifdef ROB_HEAD_BYPASS_EN
    else if (mq.size() > 0 && wb_valid && int'(wb_tag) == mq[0].tag) begin
      do_ret = 1'b1;
      rdata  = wb_data;
    end
`endif
    if (wb_valid && wb_tag != '0) begin
      foreach (mq[i]) begin
        if (mq[i].tag == int'(wb_tag)) begin
          mq[i].rdy  = 1'b1;
          mq[i].data = wb_data;
        end
      end
    end
    if (do_ret) begin
      e = mq.pop_front();
      if (e.rd != 0) begin
        m_commit = 1'b1;
        m_creg   = 32'(e.rd);
        m_cdata  = rdata;
        m_ctag   = 32'(e.tag);
      end
    end
    if (alloc_valid && can_alloc) begin
      mq.push_back('{m_next, int'(alloc_rd), 1'b0, 32'h0});
      m_next = (m_next == DEPTH) ? 1 : m_next + 1;
    end
  endtask

  // One clock cycle: check at the falling edge, step the model, land 1ns
  // after the rising edge.
  task automatic tick();
    @(negedge clk);
    compare_model();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_alloc(input logic [4:0] rd);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic do_wb(input logic [TAG_W-1:0] tag, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_tag   = tag;
    wb_data  = data;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; pause = 1'b0; flush = 1'b0;
    alloc_valid = 1'b0; alloc_rd = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_data = '0; query_tag = '0;
    m_next = 1; m_commit = 1'b0; m_creg = 0; m_cdata = 0; m_ctag = 0;

    // ---- reset ----
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
    tick();
    rst = 1'b1;
    settle();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd1);
    chk("rst_commit", 32'(commit), 32'd0);
    chk("rst_commit_reg", 32'(commit_reg), 32'd0);
    chk("rst_commit_data", commit_data, 32'd0);
    chk("rst_commit_tag", 32'(commit_tag), 32'd0);
    chk("rst_query_data", query_data, 32'd0);

    // ---- allocate rd 5,6,7 and retire out-of-order writebacks in order ----
    alloc_valid = 1'b1;
    alloc_rd = 5'd5; settle(); chk("a1_tag", 32'(alloc_tag), 32'd1); tick();
    alloc_rd = 5'd6; settle(); chk("a2_tag", 32'(alloc_tag), 32'd2); tick();
    alloc_rd = 5'd7; settle(); chk("a3_tag", 32'(alloc_tag), 32'd3); tick();
    alloc_valid = 1'b0;
    settle();
    chk("a_count", 32'(count), 32'd3);
    do_wb(3'd2, 32'hBEEF);
    do_wb(3'd1, 32'h1234);
`ifndef ROB_HEAD_BYPASS_EN
    tick();
`endif
    chk("c1_commit", 32'(commit), 32'd1);
    chk("c1_reg", 32'(commit_reg), 32'd5);
    chk("c1_data", commit_data, 32'h1234);
    chk("c1_tag", 32'(commit_tag), 32'd1);
    tick();
    chk("c2_commit", 32'(commit), 32'd1);
    chk("c2_reg", 32'(commit_reg), 32'd6);
    chk("c2_data", commit_data, 32'hBEEF);
    chk("c2_tag", 32'(commit_tag), 32'd2);
    tick();
    chk("c3_commit", 32'(commit), 32'd0);
    chk("c3_count", 32'(count), 32'd1);

    // ---- fill, full, wrap ----
    rst = 1'b0; tick(); rst = 1'b1;
    alloc_valid = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      alloc_rd = 5'(i);
      tick();
    end
    settle();
    chk("full_ready", 32'(alloc_ready), 32'd0);
    chk("full_count", 32'(count), 32'd7);
    tick();
    chk("full_hold_count", 32'(count), 32'd7);
    wb_valid = 1'b1; wb_tag = 3'd1; wb_data = 32'hC0DE;
    tick();
    wb_valid = 1'b0;
`ifndef ROB_HEAD_BYPASS_EN
    tick();
`endif
    settle();
    chk("wrap_count", 32'(count), 32'd6);
    chk("wrap_ready", 32'(alloc_ready), 32'd1);
    chk("wrap_tag", 32'(alloc_tag), 32'd1);
    chk("wrap_commit", 32'(commit), 32'd1);
    chk("wrap_data", commit_data, 32'hC0DE);
    tick();
    alloc_valid = 1'b0;
    chk("refill_count", 32'(count), 32'd7);

    // ---- flush, then a silent rd=0 retirement ----
    flush = 1'b1; tick(); flush = 1'b0;
    settle();
    chk("fl1_count", 32'(count), 32'd0);
    chk("fl1_commit", 32'(commit), 32'd0);
    chk("fl1_tag", 32'(alloc_tag), 32'd1);
    chk("fl1_reg_hold", 32'(commit_reg), 32'd1);
    do_alloc(5'd0);
    tick();
    do_wb(3'd1, 32'hFF);
`ifndef ROB_HEAD_BYPASS_EN
    tick();
`endif
    chk("z_commit", 32'(commit), 32'd0);
    chk("z_count", 32'(count), 32'd0);
    chk("z_reg_hold", 32'(commit_reg), 32'd1);
    chk("z_data_hold", commit_data, 32'hC0DE);

    // ---- allocation and retirement on the same edge ----
    do_alloc(5'd3);
`ifdef ROB_HEAD_BYPASS_EN
    wb_valid = 1'b1; wb_tag = 3'd2; wb_data = 32'h33;
    alloc_valid = 1'b1; alloc_rd = 5'd4;
    tick();
    wb_valid = 1'b0; alloc_valid = 1'b0;
`else
    do_wb(3'd2, 32'h33);
    do_alloc(5'd4);
`endif
    chk("ar_count", 32'(count), 32'd1);
    chk("ar_commit", 32'(commit), 32'd1);
    chk("ar_reg", 32'(commit_reg), 32'd3);
    chk("ar_tag", 32'(commit_tag), 32'd2);
    chk("ar_data", commit_data, 32'h33);
    do_wb(3'd3, 32'h44);
`ifndef ROB_HEAD_BYPASS_EN
    tick();
`endif
    chk("ar2_tag", 32'(commit_tag), 32'd3);
    chk("ar2_count", 32'(count), 32'd0);

    // ---- query, then pause with a ready head ----
    rst = 1'b0; tick(); rst = 1'b1;
    do_alloc(5'd10);
    do_alloc(5'd11);
    do_alloc(5'd12);
    query_tag = 3'd3;
    settle();
    chk("q_before_ready", 32'(query_ready), 32'd0);
    do_wb(3'd3, 32'hA5A5);
    settle();
    chk("q_after_ready", 32'(query_ready), 32'd1);
    chk("q_after_data", query_data, 32'hA5A5);
    do_wb(3'd2, 32'h222);
    do_wb(3'd1, 32'h111);
`ifndef ROB_HEAD_BYPASS_EN
    tick();
`endif
    chk("p0_commit", 32'(commit), 32'd1);
    chk("p0_tag", 32'(commit_tag), 32'd1);
    chk("p0_data", commit_data, 32'h111);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pz_commit", 32'(commit), 32'd0);
      chk("pz_count", 32'(count), 32'd2);
    end
    pause = 1'b0;
    tick();
    chk("p1_commit", 32'(commit), 32'd1);
    chk("p1_tag", 32'(commit_tag), 32'd2);
    chk("p1_data", commit_data, 32'h222);
    tick();
    chk("p2_tag", 32'(commit_tag), 32'd3);
    chk("p2_data", commit_data, 32'hA5A5);
    tick();
    chk("p3_commit", 32'(commit), 32'd0);
    chk("p3_count", 32'(count), 32'd0);

    // ---- overwrite, flush with partial readiness, late writeback ----
    for (int i = 1; i <= 4; i++) do_alloc(5'(i));
    do_wb(3'd5, 32'h55);
    do_wb(3'd6, 32'h66);
    do_wb(3'd5, 32'h5A);
    query_tag = 3'd5;
    settle();
    chk("ow_data", query_data, 32'h5A);
    chk("ow_count", 32'(count), 32'd4);
    pause = 1'b1; flush = 1'b1;
    tick();
    pause = 1'b0; flush = 1'b0;
    settle();
    chk("fl2_count", 32'(count), 32'd0);
    chk("fl2_commit", 32'(commit), 32'd0);
    chk("fl2_tag", 32'(alloc_tag), 32'd1);
    do_wb(3'd2, 32'h77);
    query_tag = 3'd2;
    settle();
    chk("fl2_late_wb", 32'(query_ready), 32'd0);
    do_wb(3'd0, 32'h99);
    tick();

    // ---- reset mid-operation drops entries silently ----
    do_alloc(5'd9);
    do_wb(3'd1, 32'h99);
    rst = 1'b0; tick(); rst = 1'b1;
    settle();
    chk("mr_commit", 32'(commit), 32'd0);
    chk("mr_count", 32'(count), 32'd0);
    chk("mr_reg", 32'(commit_reg), 32'd0);
    chk("mr_data", commit_data, 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement buffer that hands out the 3-bit dependency tags consumed by the register file and later drives its commit port. Each issued instruction gets an entry and a tag (1..7, tag 0 means "no dependency"). Execution units write results back by tag. Finished results retire strictly in program order as one-cycle commit pulses carrying {reg, data, tag}, which the register file uses to write the value and clear a matching dependency. The block sits between issue/dispatch and the register file.

## Interface
- TAG_W, 3, tag width; entry count is 2^TAG_W-1 (7); tag 0 reserved
- DATA_W, 32, result width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low (0 = reset)
- pause  in  1  freeze all state for this cycle
- flush  in  1  discard all entries (mispredict recovery)
- alloc_valid  in  1  issue stage requests an entry
- alloc_rd  in  5  destination register of the allocating instruction
- alloc_ready  out  1  an entry is free (count < 7)
- alloc_tag  out  TAG_W  tag granted on this cycle's allocation; feeds register-file dependency_num
- wb_valid  in  1  result writeback strobe
- wb_tag  in  TAG_W  tag of the finished instruction
- wb_data  in  DATA_W  result value
- query_tag  in  TAG_W  tag probed by a reservation station
- query_ready  out  1  probed entry is valid and has its result
- query_data  out  DATA_W  result of the probed entry
- commit  out  1  one-cycle retirement pulse to the register file
- commit_reg  out  5  retiring destination register
- commit_data  out  DATA_W  retiring value
- commit_tag  out  TAG_W  retiring tag (register file num_in)
- count  out  TAG_W  occupied entries, 0..7

## Operation
- Storage: 7 slots. Slot i holds tag i+1. Per slot: valid, ready, rd, data. head and tail are slot indices 0..6 and wrap from 6 to 0.
- Allocation happens when alloc_valid && alloc_ready && !pause && !flush:
  - write slot[tail] with valid=1, ready=0, rd=alloc_rd;
  - advance tail and increment count.
- alloc_tag = tail+1. It is combinational and valid whenever alloc_ready=1.
- Writeback happens when wb_valid && !pause && !flush. If wb_tag is 1..7 and that slot is valid, set ready=1 and latch data.
  - wb_tag=0 is ignored.
  - A writeback to an invalid slot is ignored.
  - A writeback to an already-ready slot overwrites its data.
- Retirement: at an edge where count>0 and slot[head] is valid && ready (state before the edge):
  - free the slot, advance head, decrement count;
  - if rd≠0, register commit=1 with commit_reg, commit_data and commit_tag taken from the head slot;
  - if rd=0, retire silently: commit=0, outputs hold.
- At most one retirement per cycle.
- Allocation and retirement on the same edge leave count unchanged.
- A full buffer does not see the slot freed by a same-edge retirement; alloc_ready is computed from the pre-edge count.
- Query: query_ready and query_data are combinational reads of slot[query_tag-1]. query_tag=0 gives query_ready=0 and query_data=0.
- Flush takes priority over alloc, wb and retire:
  - clear all valid bits;
  - set head=tail=count=0;
  - register commit=0.
- Pause:
  - all slots, pointers and count hold;
  - commit registers 0 on that edge, so no retirement is ever repeated;
  - the other commit_* outputs hold.

## Timing
- Reset (rst=0 at an edge):
  - head=tail=count=0, all valid/ready=0;
  - commit=0, commit_reg=0, commit_data=0, commit_tag=0;
  - alloc_ready=1 and alloc_tag=1 afterwards.
- Reset has priority over flush and pause.
- Reset mid-operation drops all entries without emitting commits.
- Allocation to tag visible in a slot: 1 edge.
- Writeback at edge N: the entry becomes ready at N. If it is the head, commit is high during cycle N+1 to N+2, i.e. registered at edge N+1.
- Minimum alloc-to-commit: 3 edges (alloc N, wb N+1, commit N+2).
- commit is never high on two consecutive cycles for the same tag.

## Configuration
- ROB_HEAD_BYPASS_EN
  - Defined: a writeback whose wb_tag equals the head tag, arriving while the head is not ready, retires at the same edge. commit_data takes wb_data directly, saving one cycle (wb at N, commit registered at N).
  - Undefined: the two-edge path described above.
- Flush, pause and reset priorities are identical in both builds.

## Test plan
- Reset then allocate rd=5,6,7 -> alloc_tag 1,2,3, count=3. Write back tag 2 (0xBEEF) then tag 1 (0x1234) -> commits {5,0x1234,1} then {6,0xBEEF,2} on consecutive cycles. Tag 3 is held.
- Fill 7 entries -> alloc_ready=0, count=7. Write back head -> retire, then alloc_ready=1 and alloc_tag=1 (wrap).
- Allocate rd=0, write back 0xFF -> entry retires with commit=0, count drops by 1.
- Ready head with pause=1 for 3 cycles -> no commit, count held. Release pause -> exactly one commit.
- 4 entries with 2 ready, assert flush -> commit=0 thereafter, count=0, next alloc_tag=1. A writeback to tag 2 after the flush is ignored.
- Query tag 3 before and after its writeback of 0xA5A5 -> query_ready 0→1, query_data=0xA5A5. With ROB_HEAD_BYPASS_EN, a head writeback commits at the same edge.
